// File: rtl/pool_max2x2_pkg.sv
// -----------------------------------------------------------------------------
// pool_max2x2_pkg
// Shared constants for the 2x2 max-pooling layer that sits between the second
// conv layer and the fully-connected stage: word/address widths, DRAM base
// addresses of the input (ifmap) and output (ofmap) maps, layer dimensions and
// the one-hot FSM state bit positions. Also provides the signed max helper.
// -----------------------------------------------------------------------------
package pool_max2x2_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 18;

    // DRAM word addresses of the conv2 output map and of the FC input map.
    localparam logic [17:0] IFMAP_BASE = 18'd65536;
    localparam logic [17:0] OFMAP_BASE = 18'd131072;

    // Layer geometry: 10x10x16 in, 5x5x16 out.
    localparam int unsigned IN_DIM  = 10;
    localparam int unsigned OUT_DIM = IN_DIM / 2;
    localparam int unsigned NUM_CH  = 16;

    // Last index of each traversal counter.
    localparam logic [1:0] K_LAST  = 2'd3;
    localparam logic [2:0] XO_LAST = 3'(OUT_DIM - 1);
    localparam logic [2:0] YO_LAST = 3'(OUT_DIM - 1);
    localparam logic [3:0] Z_LAST  = 4'(NUM_CH - 1);

    // One-hot state bit positions.
    localparam int unsigned ST_IDLE  = 0;
    localparam int unsigned ST_READ  = 1;
    localparam int unsigned ST_DRAIN = 2;
    localparam int unsigned ST_DONE  = 3;

    // Two's-complement maximum; 0x80000000 is the smallest value.
    function automatic logic [DATA_WIDTH-1:0] signed_max(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        if ($signed(a) > $signed(b)) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/pool_max2x2_addr_gen.sv
// -----------------------------------------------------------------------------
// pool_addr_gen
// Window traversal counters for the pooling layer. k (window element) is the
// fastest counter, then xo, yo, z. Forms the DRAM read address for the element
// currently being fetched.
// Ports:
//   clk, srstn     clock, asynchronous active-low reset
//   adv_i          high during READ: issue a read and advance the counters
//   addr_in_o      read address (0 when adv_i is low)
//   last_o         the current read is k=3 of the final window
//   k_o/xo_o/yo_o/z_o  current counter values, for the top's delay pipeline
// -----------------------------------------------------------------------------
module pool_addr_gen
    import pool_max2x2_pkg::*;
#(
    parameter int unsigned             AW      = ADDR_WIDTH,
    parameter logic [AW-1:0]           IN_BASE = IFMAP_BASE
) (
    input  logic          clk,
    input  logic          srstn,
    input  logic          adv_i,
    output logic [AW-1:0] addr_in_o,
    output logic          last_o,
    output logic [1:0]    k_o,
    output logic [2:0]    xo_o,
    output logic [2:0]    yo_o,
    output logic [3:0]    z_o
);

    logic [1:0] k_q,  k_d;
    logic [2:0] xo_q, xo_d;
    logic [2:0] yo_q, yo_d;
    logic [3:0] z_q,  z_d;

    // Counter next-state: each counter wraps at its last value and carries on.
    always_comb begin
        k_d  = k_q;
        xo_d = xo_q;
        yo_d = yo_q;
        z_d  = z_q;
        if (adv_i) begin
            if (k_q == K_LAST) begin
                k_d = 2'd0;
                if (xo_q == XO_LAST) begin
                    xo_d = 3'd0;
                    if (yo_q == YO_LAST) begin
                        yo_d = 3'd0;
                        if (z_q == Z_LAST) begin
                            z_d = 4'd0;
                        end else begin
                            z_d = z_q + 4'd1;
                        end
                    end else begin
                        yo_d = yo_q + 3'd1;
                    end
                end else begin
                    xo_d = xo_q + 3'd1;
                end
            end else begin
                k_d = k_q + 2'd1;
            end
        end else begin
            k_d = k_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            k_q  <= 2'd0;
            xo_q <= 3'd0;
            yo_q <= 3'd0;
            z_q  <= 4'd0;
        end else begin
            k_q  <= k_d;
            xo_q <= xo_d;
            yo_q <= yo_d;
            z_q  <= z_d;
        end
    end

    // y = 2*yo + k[1] and x = 2*xo + k[0] are plain bit concatenations, so the
    // {z, y[4:0], x[4:0]} field is assembled directly from the counters.
    assign addr_in_o = adv_i
        ? IN_BASE + AW'({z_q, 1'b0, yo_q, k_q[1], 1'b0, xo_q, k_q[0]})
        : '0;

    assign last_o = (k_q == K_LAST) && (xo_q == XO_LAST) &&
                    (yo_q == YO_LAST) && (z_q == Z_LAST);
    assign k_o  = k_q;
    assign xo_o = xo_q;
    assign yo_o = yo_q;
    assign z_o  = z_q;

endmodule

// File: rtl/pool_max2x2.sv
// -----------------------------------------------------------------------------
// pool_max2x2
// 2x2 stride-2 max pooling of the 10x10x16 conv2 output map held in DRAM,
// writing the 5x5x16 result in packed {z,y,x} layout for the FC stage.
// Ports:
//   clk, srstn   clock, asynchronous active-low reset
//   enable       start request, only honoured in IDLE
//   dram_valid   unused (read latency is a fixed single cycle)
//   data_in      read data for the address presented the previous cycle
//   data_out     pooled value being written (held until the next write)
//   addr_in      read address, 0 outside READ
//   addr_out     write address (held until the next write)
//   dram_en_wr   one-cycle write strobe per output word
//   dram_en_rd   read enable, high exactly while in READ
//   done         one-cycle completion pulse
// -----------------------------------------------------------------------------
module pool_max2x2
    import pool_max2x2_pkg::*;
#(
    parameter int unsigned               DATA_WIDTH = pool_max2x2_pkg::DATA_WIDTH,
    parameter int unsigned               ADDR_WIDTH = pool_max2x2_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]     IN_BASE    = IFMAP_BASE,
    parameter logic [ADDR_WIDTH-1:0]     OUT_BASE   = OFMAP_BASE
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  enable,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  dram_en_wr,
    output logic                  dram_en_rd,
    output logic                  done
);

    localparam logic [3:0] S_IDLE  = 4'(1 << ST_IDLE);
    localparam logic [3:0] S_READ  = 4'(1 << ST_READ);
    localparam logic [3:0] S_DRAIN = 4'(1 << ST_DRAIN);
    localparam logic [3:0] S_DONE  = 4'(1 << ST_DONE);

    logic [3:0]            state_q, state_d;
    logic                  drain_q, drain_d;
    logic                  load_q;
    logic [1:0]            k_dly_q;
    logic [2:0]            xo_dly_q, yo_dly_q;
    logic [3:0]            z_dly_q;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [ADDR_WIDTH-1:0] addr_out_q, addr_out_d;
    logic                  wr_q, wr_d;

    logic                  reading_s;
    logic                  last_s;
    logic [1:0]            k_s;
    logic [2:0]            xo_s, yo_s;
    logic [3:0]            z_s;
    logic [DATA_WIDTH-1:0] cand_s;
    logic                  unused_dram_valid_s;

    assign unused_dram_valid_s = dram_valid;
    assign reading_s           = state_q[ST_READ];

    pool_addr_gen #(
        .AW      (ADDR_WIDTH),
        .IN_BASE (IN_BASE)
    ) u_addr_gen (
        .clk       (clk),
        .srstn     (srstn),
        .adv_i     (reading_s),
        .addr_in_o (addr_in),
        .last_o    (last_s),
        .k_o       (k_s),
        .xo_o      (xo_s),
        .yo_o      (yo_s),
        .z_o       (z_s)
    );

    // FSM next-state; DRAIN covers the two cycles the last read needs to
    // come back and be written.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                drain_d = 1'b0;
                if (last_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                if (drain_q) begin
                    state_d = S_DONE;
                    drain_d = 1'b0;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                drain_d = 1'b0;
            end
        endcase
    end

    // FSM registers.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q <= S_IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Delay pipeline: tags each returning read word with its window position.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            load_q   <= 1'b0;
            k_dly_q  <= 2'd0;
            xo_dly_q <= 3'd0;
            yo_dly_q <= 3'd0;
            z_dly_q  <= 4'd0;
        end else begin
            load_q   <= reading_s;
            k_dly_q  <= k_s;
            xo_dly_q <= xo_s;
            yo_dly_q <= yo_s;
            z_dly_q  <= z_s;
        end
    end

    assign cand_s = signed_max(max_q, data_in);

    // Running max and write port; k=0 restarts the max, k=3 emits the result.
    always_comb begin
        max_d      = max_q;
        data_out_d = data_out_q;
        addr_out_d = addr_out_q;
        wr_d       = 1'b0;
        if (load_q) begin
            if (k_dly_q == 2'd0) begin
                max_d = data_in;
            end else begin
                max_d = cand_s;
            end
            if (k_dly_q == K_LAST) begin
                data_out_d = cand_s;
                addr_out_d = OUT_BASE +
                    ADDR_WIDTH'({z_dly_q, 2'b00, yo_dly_q, 2'b00, xo_dly_q});
                wr_d       = 1'b1;
            end else begin
                wr_d = 1'b0;
            end
        end else begin
            wr_d = 1'b0;
        end
    end

    // Max and output registers.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            max_q      <= '0;
            data_out_q <= '0;
            addr_out_q <= '0;
            wr_q       <= 1'b0;
        end else begin
            max_q      <= max_d;
            data_out_q <= data_out_d;
            addr_out_q <= addr_out_d;
            wr_q       <= wr_d;
        end
    end

    assign data_out   = data_out_q;
    assign addr_out   = addr_out_q;
    assign dram_en_wr = wr_q;
    assign dram_en_rd = reading_s;
    assign done       = state_q[ST_DONE];

endmodule

// File: tb/tb_pool_max2x2.sv
// -----------------------------------------------------------------------------
// tb_pool_max2x2
// Self-checking bench for pool_max2x2: a one-cycle-latency DRAM model feeds
// random, directed and ramp feature maps; expected pooled values come from a
// window-max reference computed directly over the input array.
// -----------------------------------------------------------------------------
module tb_pool_max2x2;

    localparam int IN_B  = 65536;
    localparam int OUT_B = 131072;

    logic        clk = 1'b0;
    logic        srstn;
    logic        enable;
    logic        dram_valid;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [17:0] addr_in;
    logic [17:0] addr_out;
    logic        dram_en_wr;
    logic        dram_en_rd;
    logic        done;

    logic [31:0] mem     [0:16383];
    logic [31:0] out_mem [0:16383];

    int checks   = 0;
    int failures = 0;

    pool_max2x2 dut (
        .clk        (clk),
        .srstn      (srstn),
        .enable     (enable),
        .dram_valid (dram_valid),
        .data_in    (data_in),
        .data_out   (data_out),
        .addr_in    (addr_in),
        .addr_out   (addr_out),
        .dram_en_wr (dram_en_wr),
        .dram_en_rd (dram_en_rd),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input logic [17:0] a);
        int off;
        off = int'(a) - IN_B;
        if (off < 0 || off > 16383) return 32'hDEADBEEF;
        return mem[off];
    endfunction

    // DRAM read port: data for the address seen at an edge appears after it.
    always @(posedge clk) begin
        if (dram_en_rd) data_in <= rd_word(addr_in);
    end

    // Reference: signed maximum of the 2x2 input window under output (z,y,x).
    function automatic logic [31:0] exp_pool(input int z, input int y, input int x);
        logic signed [31:0] best;
        logic signed [31:0] v;
        best = $signed(mem[z*1024 + (2*y)*32 + 2*x]);
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                v = $signed(mem[z*1024 + (2*y+dy)*32 + 2*x + dx]);
                if (v > best) best = v;
            end
        end
        return best;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16384; i++) mem[i] = $urandom();
        // all-negative window {-5,-1,-7,-3} at (0,0,0)
        mem[0]  = 32'(-5 * 65536);
        mem[1]  = 32'(-1 * 65536);
        mem[32] = 32'(-7 * 65536);
        mem[33] = 32'(-3 * 65536);
        // all-minimum window at (0,0,1)
        mem[2]  = 32'h80000000;
        mem[3]  = 32'h80000000;
        mem[34] = 32'h80000000;
        mem[35] = 32'h80000000;
        // extremes at (0,0,2)
        mem[4]  = 32'h7FFFFFFF;
        mem[5]  = 32'h80000000;
        mem[36] = 32'h00000000;
        mem[37] = 32'h00000001;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 16384; i++) mem[i] = 32'(i) << 16;
    endtask

    // Starts a run (enable seen at the cycle-0 edge) and checks every cycle
    // 1..1605 against the expected schedule; hold keeps enable high throughout.
    task automatic run_check(input bit hold, input bit pulse);
        int rd_err = 0, ain_err = 0, wr_err = 0, aout_err = 0, dat_err = 0;
        int done_err = 0, nwr = 0, i, k, w, j, off;
        bit exp_rd, exp_wr, seen;
        logic [17:0] exp_a;
        logic [17:0] first_ain [1:4];
        logic [17:0] first_aout = '0;
        for (int a = 0; a < 16384; a++) out_mem[a] = 32'h0;
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) enable = 1'b0;
        for (int c = 1; c <= 1605; c++) begin
            @(negedge clk);
            exp_rd = (c <= 1600) || (hold && c == 1605);
            if (c <= 1600) begin
                i = c - 1; k = i % 4; w = i / 4;
                exp_a = 18'(IN_B + (w/25)*1024 + (2*((w/5)%5) + k/2)*32 + 2*(w%5) + k%2);
            end else if (hold && c == 1605) begin
                exp_a = 18'(IN_B);
            end else begin
                exp_a = 18'd0;
            end
            if (c <= 4) first_ain[c] = addr_in;
            if (dram_en_rd !== exp_rd) rd_err++;
            if (addr_in !== exp_a) ain_err++;
            exp_wr = (c >= 6) && (c <= 1602) && ((c - 6) % 4 == 0);
            if (dram_en_wr !== exp_wr) wr_err++;
            if (dram_en_wr === 1'b1) begin
                nwr++;
                if (c == 6) first_aout = addr_out;
                if (exp_wr) begin
                    j = (c - 6) / 4;
                    if (addr_out !== 18'(OUT_B + (j/25)*1024 + ((j/5)%5)*32 + j%5)) aout_err++;
                    if (data_out !== exp_pool(j/25, (j/5)%5, j%5)) dat_err++;
                end
                off = int'(addr_out) - OUT_B;
                if (off >= 0 && off < 16384) out_mem[off] = data_out;
            end
            if (done !== (c == 1603)) done_err++;
            if (pulse && (c == 100 || c == 1601)) enable = 1'b1;
            if (pulse && (c == 101 || c == 1602)) enable = 1'b0;
        end
        chk("first_addr_in0", 32'(first_ain[1]), 32'd65536);
        chk("first_addr_in1", 32'(first_ain[2]), 32'd65537);
        chk("first_addr_in2", 32'(first_ain[3]), 32'd65568);
        chk("first_addr_in3", 32'(first_ain[4]), 32'd65569);
        chk("first_addr_out", 32'(first_aout), 32'd131072);
        chk("rd_en_window_errs", 32'(rd_err), 32'd0);
        chk("addr_in_errs", 32'(ain_err), 32'd0);
        chk("wr_strobe_errs", 32'(wr_err), 32'd0);
        chk("addr_out_errs", 32'(aout_err), 32'd0);
        chk("data_out_errs", 32'(dat_err), 32'd0);
        chk("done_timing_errs", 32'(done_err), 32'd0);
        chk("write_count", 32'(nwr), 32'd400);
        if (hold) begin
            enable = 1'b0;
            nwr = 0;
            seen = 1'b0;
            for (int c = 0; c < 2000 && !seen; c++) begin
                @(negedge clk);
                if (dram_en_wr === 1'b1) nwr++;
                if (done === 1'b1) seen = 1'b1;
            end
            chk("second_run_done", 32'(seen), 32'd1);
            chk("second_run_writes", 32'(nwr), 32'd400);
        end
    endtask

    initial begin
        int nwr, bad;
        enable     = 1'b0;
        dram_valid = 1'b0;
        srstn      = 1'b1;
        #2 srstn = 1'b0;
        #10;
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_addr_out", 32'(addr_out), 32'd0);
        chk("rst_addr_in", 32'(addr_in), 32'd0);
        chk("rst_wr", 32'(dram_en_wr), 32'd0);
        chk("rst_rd", 32'(dram_en_rd), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        srstn = 1'b1;
        repeat (3) @(negedge clk);

        // Random map with directed windows; enable pulses mid-run are ignored.
        fill_random();
        run_check(1'b0, 1'b1);
        chk("neg_window", out_mem[0], 32'hFFFF0000);
        chk("min_window", out_mem[1], 32'h80000000);
        chk("extreme_window", out_mem[2], 32'h7FFFFFFF);
        repeat (5) @(negedge clk);

        // Asynchronous reset in the middle of a ramp run.
        fill_ramp();
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (799) @(negedge clk);
        @(posedge clk);
        #2 srstn = 1'b0;
        #1;
        chk("midrst_data_out", data_out, 32'd0);
        chk("midrst_addr_out", 32'(addr_out), 32'd0);
        chk("midrst_addr_in", 32'(addr_in), 32'd0);
        chk("midrst_wr", 32'(dram_en_wr), 32'd0);
        chk("midrst_rd", 32'(dram_en_rd), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        srstn = 1'b1;
        nwr = 0;
        repeat (1700) begin
            @(negedge clk);
            if (dram_en_wr !== 1'b0 || dram_en_rd !== 1'b0) nwr++;
        end
        chk("post_rst_activity", 32'(nwr), 32'd0);

        // Full ramp run after the aborted one, checked against the closed form.
        run_check(1'b0, 1'b0);
        bad = 0;
        for (int z = 0; z < 16; z++)
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++)
                    if (out_mem[z*1024 + y*32 + x] !== (32'(z*1024 + (2*y+1)*32 + 2*x + 1) << 16))
                        bad++;
        chk("ramp_result_errs", 32'(bad), 32'd0);
        repeat (5) @(negedge clk);

        // Enable held high: back-to-back runs.
        fill_random();
        run_check(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
